frame_req_sequencer: RTL and testbench

//  Per-frame req/ack scheduler between the collision engine and N_CH object blocks (ball, platform, gadget, brick...).
//  On each i_cal_frame pulse it walks the enabled channels in index order, re-requests each until it reports frame_term,

---
 rtl/game_pkg.sv | 10 +
 rtl/chan_pick.sv | 21 ++
 rtl/frame_req_sequencer.sv | 104 ++++++++++
 tb/tb_frame_req_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared game constants and the frame sequencer state type
package game_pkg;
   localparam int PIXEL_X_W       = 10;
   localparam int PIXEL_Y_W       = 10;
   localparam int DIR_W           = 2;
   localparam int N_CH_DEF        = 4;
   localparam int TIMEOUT_CYC_DEF = 1024;
   localparam int MAX_ROUNDS_DEF  = 8;
   typedef enum logic [1:0] {IDLE, NEXT, REQ, DONE} seq_state_t;
endpackage

// File: rtl/chan_pick.sv
// chan_pick: lowest set bit of mask at or above start; start past the top finds nothing
module chan_pick #(
   parameter int N  = 4,
   parameter int CW = 2,
   parameter int SW = 3
) (
   input  logic [N-1:0]  mask,
   input  logic [SW-1:0] start,
   output logic          found,
   output logic [CW-1:0] idx
);
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--)
         if (mask[i] && i >= int'(start)) begin
            found = 1'b1;
            idx   = CW'(i);
         end
   end
endmodule

// File: rtl/frame_req_sequencer.sv
// frame_req_sequencer: per-frame req/ack scheduler walking enabled object channels in index order
// with per-request timeout and per-channel round limit
module frame_req_sequencer
   import game_pkg::*;
#(
   parameter int  N_CH        = N_CH_DEF,
   parameter int  TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int  MAX_ROUNDS  = MAX_ROUNDS_DEF,
   localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_cal_frame,
   input  logic            i_game_start,
   input  logic [N_CH-1:0] i_ch_enable,
   output logic [N_CH-1:0] o_req,
   input  logic [N_CH-1:0] i_ack,
   input  logic [N_CH-1:0] i_frame_term,
   output logic            o_busy,
   output logic [CH_W-1:0] o_active_ch,
   output logic            o_frame_done,
   output logic [N_CH-1:0] o_timeout_mask,
   output logic [N_CH-1:0] o_overrun_mask,
   output logic            o_missed_frame,
   output logic [15:0]     o_frame_cnt
);
   localparam int SW = $clog2(N_CH + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int RW = $clog2(MAX_ROUNDS + 1);

   seq_state_t      state, state_n;
   logic [N_CH-1:0] en;
   logic [SW-1:0]   start;
   logic [TW-1:0]   tcnt;
   logic [RW-1:0]   round_cnt, round_inc;
   logic [CH_W-1:0] pick_idx;
   logic            found, ack_hit, term, tmo, ovr, adv;

   chan_pick #(.N(N_CH), .CW(CH_W), .SW(SW)) u_pick (
      .mask (en),
      .start(start),
      .found(found),
      .idx  (pick_idx)
   );

   // adv: the current channel is finished for this frame, move the start index past it
   always_comb begin
      ack_hit        = (state == REQ) && i_ack[o_active_ch];
      term           = i_frame_term[o_active_ch];
      tmo            = (state == REQ) && (tcnt == TW'(TIMEOUT_CYC - 1));
      round_inc      = round_cnt + RW'(1);
      ovr            = ack_hit && !term && (round_inc == RW'(MAX_ROUNDS));
      adv            = ack_hit ? (term || ovr) : tmo;
      state_n        = i_game_start     ? IDLE :
                       (state == IDLE)  ? (i_cal_frame ? NEXT : IDLE) :
                       (state == NEXT)  ? (found ? REQ : DONE) :
                       (state == REQ)   ? ((ack_hit || tmo) ? NEXT : REQ) : IDLE;
      o_req          = (state == REQ) ? (N_CH'(1'b1) << o_active_ch) : '0;
      o_busy         = state != IDLE;
      o_frame_done   = state == DONE;
      o_missed_frame = i_cal_frame && (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state          <= IDLE;
         en             <= '0;
         start          <= '0;
         tcnt           <= '0;
         round_cnt      <= '0;
         o_active_ch    <= '0;
         o_timeout_mask <= '0;
         o_overrun_mask <= '0;
         o_frame_cnt    <= '0;
      end else begin
         state <= state_n;
         if (i_game_start) begin
            o_timeout_mask <= '0;
            o_overrun_mask <= '0;
            round_cnt      <= '0;
            tcnt           <= '0;
         end else begin
            if (state == IDLE && i_cal_frame) begin
               en             <= i_ch_enable;
               start          <= '0;
               round_cnt      <= '0;
               o_timeout_mask <= '0;
               o_overrun_mask <= '0;
            end
            if (state == NEXT) begin
               tcnt <= '0;
               if (found) o_active_ch <= pick_idx;
            end
            if (state == REQ) begin
               tcnt      <= tcnt + TW'(1);
               round_cnt <= adv ? '0 : ack_hit ? round_inc : round_cnt;
               if (adv) start <= SW'(o_active_ch) + SW'(1);
               if (tmo && !ack_hit) o_timeout_mask[o_active_ch] <= 1'b1;
               if (ovr) o_overrun_mask[o_active_ch] <= 1'b1;
            end
            if (state == DONE) o_frame_cnt <= o_frame_cnt + 16'd1;
         end
      end
endmodule

// File: tb/tb_frame_req_sequencer.sv
// tb_frame_req_sequencer: directed frames with an object-block responder; request pulses and
// frame-done status are checked against scoreboard queues filled before each frame starts
module tb_frame_req_sequencer;
   logic        clk = 1'b0;
   logic        rst_n, i_cal_frame, i_game_start;
   logic [3:0]  i_ch_enable, o_req, i_ack, i_frame_term, o_timeout_mask, o_overrun_mask;
   logic        o_busy, o_frame_done, o_missed_frame;
   logic [1:0]  o_active_ch;
   logic [15:0] o_frame_cnt;

   typedef struct {int ch; int len;} pulse_t;
   typedef struct {logic [3:0] tm; logic [3:0] om;} done_t;
   pulse_t exp_pulse[$];
   done_t  exp_done[$];
   int checks = 0;
   int errors = 0;
   int ack_dly = 3;
   bit stray = 1'b0;
   logic [7:0] term_seq [4];
   int term_n [4];

   frame_req_sequencer #(.N_CH(4), .TIMEOUT_CYC(16), .MAX_ROUNDS(3)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_cal_frame   (i_cal_frame),
      .i_game_start  (i_game_start),
      .i_ch_enable   (i_ch_enable),
      .o_req         (o_req),
      .i_ack         (i_ack),
      .i_frame_term  (i_frame_term),
      .o_busy        (o_busy),
      .o_active_ch   (o_active_ch),
      .o_frame_done  (o_frame_done),
      .o_timeout_mask(o_timeout_mask),
      .o_overrun_mask(o_overrun_mask),
      .o_missed_frame(o_missed_frame),
      .o_frame_cnt   (o_frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int idx_of(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic set_term(input int ch, input logic [7:0] seq, input int n);
      term_seq[ch] = seq;
      term_n[ch]   = n;
   endtask

   task automatic push_pulse(input int ch, input int len);
      exp_pulse.push_back('{ch: ch, len: len});
   endtask

   task automatic push_done(input logic [3:0] tm, input logic [3:0] om);
      exp_done.push_back('{tm: tm, om: om});
   endtask

   task automatic run_frame(input logic [3:0] en);
      i_ch_enable = en;
      i_cal_frame = 1'b1;
      #1 chk("missed_in_idle", o_missed_frame, 0);
      @(negedge clk);
      i_cal_frame = 1'b0;
      chk("busy_after_start", o_busy, 1);
   endtask

   task automatic wait_done(input int max);
      bit hit = 1'b0;
      for (int i = 0; i < max && !hit; i++) begin
         @(negedge clk);
         hit = o_frame_done;
      end
      chk("done_within_bound", hit, 1);
   endtask

   task automatic wait_req(input int ch, input int max);
      bit hit = 1'b0;
      for (int i = 0; i < max && !hit; i++) begin
         @(negedge clk);
         hit = o_req[ch];
      end
      chk("req_within_bound", hit, 1);
   endtask

   // object-block model: ack after ack_dly cycles of request, term taken from the channel's sequence
   initial begin
      int hold = 0;
      logic [3:0] prev = '0;
      int ch;
      i_ack = '0;
      i_frame_term = '0;
      forever begin
         @(negedge clk);
         i_ack = '0;
         i_frame_term = '0;
         hold = (o_req != 0 && o_req == prev) ? hold + 1 : (o_req != 0) ? 1 : 0;
         prev = o_req;
         if (o_req != 0) begin
            ch = idx_of(o_req);
            if (hold == ack_dly && term_n[ch] > 0) begin
               i_ack[ch] = 1'b1;
               i_frame_term[ch] = term_seq[ch][0];
               term_seq[ch] = term_seq[ch] >> 1;
               term_n[ch]--;
            end
            if (stray && ch == 0 && hold == 1) begin
               i_ack[2] = 1'b1;
               i_frame_term[2] = 1'b1;
            end
         end
      end
   end

   // zcnt counts busy cycles with no request: one before every request, two (NEXT, DONE) before done
   initial begin
      logic [3:0] prev = '0;
      int len = 0;
      int zcnt = 0;
      pulse_t p;
      done_t d;
      forever begin
         @(negedge clk);
         if (o_req != 0) begin
            if (prev == 0) begin
               chk("req_gap", zcnt, 1);
               chk("req_onehot", $onehot(o_req), 1);
               chk("req_vs_active", o_req, 4'b0001 << o_active_ch);
               len = 0;
            end
            len++;
            zcnt = 0;
         end else begin
            if (prev != 0) begin
               chk("pulse_pending", exp_pulse.size() > 0, 1);
               if (exp_pulse.size() > 0) begin
                  p = exp_pulse.pop_front();
                  chk("pulse_ch", idx_of(prev), p.ch);
                  chk("pulse_len", len, p.len);
               end
            end
            zcnt = o_busy ? zcnt + 1 : 0;
         end
         if (o_frame_done) begin
            chk("done_pending", exp_done.size() > 0, 1);
            if (exp_done.size() > 0) begin
               d = exp_done.pop_front();
               chk("done_timeout_mask", o_timeout_mask, d.tm);
               chk("done_overrun_mask", o_overrun_mask, d.om);
            end
            chk("done_gap", zcnt, 2);
         end
         prev = o_req;
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) set_term(i, 8'h0, 0);
      rst_n = 1'b0;
      i_cal_frame = 1'b0;
      i_game_start = 1'b0;
      i_ch_enable = '0;
      repeat (3) @(negedge clk);
      chk("rst_req", o_req, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_active", o_active_ch, 0);
      chk("rst_done", o_frame_done, 0);
      chk("rst_tmask", o_timeout_mask, 0);
      chk("rst_omask", o_overrun_mask, 0);
      chk("rst_missed", o_missed_frame, 0);
      chk("rst_cnt", o_frame_cnt, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // enable 1011, every channel finishes on first ack: ch2 must be skipped
      ack_dly = 3;
      set_term(0, 8'b1, 1); set_term(1, 8'b1, 1); set_term(3, 8'b1, 1);
      push_pulse(0, 3); push_pulse(1, 3); push_pulse(3, 3);
      push_done(4'b0000, 4'b0000);
      run_frame(4'b1011);
      wait_done(100);
      @(negedge clk);
      chk("f1_cnt", o_frame_cnt, 1);
      chk("f1_busy", o_busy, 0);

      // ch0 needs three rounds, under the round limit
      set_term(0, 8'b100, 3);
      push_pulse(0, 3); push_pulse(0, 3); push_pulse(0, 3);
      push_done(4'b0000, 4'b0000);
      run_frame(4'b0001);
      wait_done(100);
      @(negedge clk);
      chk("f2_cnt", o_frame_cnt, 2);

      // ch1 never finishes: stopped after MAX_ROUNDS=3 acks, then ch3 served
      set_term(0, 8'b1, 1); set_term(1, 8'b000, 3); set_term(3, 8'b1, 1);
      push_pulse(0, 3); push_pulse(1, 3); push_pulse(1, 3); push_pulse(1, 3); push_pulse(3, 3);
      push_done(4'b0000, 4'b0010);
      run_frame(4'b1011);
      wait_done(100);
      @(negedge clk);
      chk("f3_cnt", o_frame_cnt, 3);

      // ch3 never acks: request held exactly TIMEOUT_CYC cycles
      set_term(0, 8'b1, 1);
      push_pulse(0, 3); push_pulse(3, 16);
      push_done(4'b1000, 4'b0000);
      run_frame(4'b1001);
      wait_done(100);
      @(negedge clk);
      chk("f4_cnt", o_frame_cnt, 4);
      chk("f4_tmask_held", o_timeout_mask, 4'b1000);

      // ack on the last cycle of the window is accepted; stray ch2 ack during ch0 ignored
      ack_dly = 16;
      stray = 1'b1;
      set_term(0, 8'b1, 1); set_term(2, 8'b1, 1);
      push_pulse(0, 16); push_pulse(2, 16);
      push_done(4'b0000, 4'b0000);
      run_frame(4'b0101);
      wait_done(100);
      @(negedge clk);
      stray = 1'b0;
      ack_dly = 3;
      chk("f5_cnt", o_frame_cnt, 5);

      // cal_frame while requesting is reported as missed and does not restart
      set_term(0, 8'b1, 1);
      push_pulse(0, 3);
      push_done(4'b0000, 4'b0000);
      run_frame(4'b0001);
      wait_req(0, 20);
      i_cal_frame = 1'b1;
      #1 chk("missed_in_req", o_missed_frame, 1);
      @(negedge clk);
      i_cal_frame = 1'b0;
      wait_done(100);
      @(negedge clk);
      chk("f6_cnt", o_frame_cnt, 6);
      chk("f6_missed_clear", o_missed_frame, 0);

      // game_start mid-request: back to idle, masks cleared, no done
      push_pulse(0, 16); push_pulse(1, 3);
      run_frame(4'b0011);
      wait_req(1, 60);
      @(negedge clk);
      @(negedge clk);
      chk("gs_tmask_before", o_timeout_mask, 4'b0001);
      i_game_start = 1'b1;
      @(negedge clk);
      i_game_start = 1'b0;
      chk("gs_req", o_req, 0);
      chk("gs_busy", o_busy, 0);
      chk("gs_tmask", o_timeout_mask, 0);
      chk("gs_omask", o_overrun_mask, 0);
      chk("gs_done", o_frame_done, 0);
      chk("gs_cnt", o_frame_cnt, 6);

      // async reset mid-request clears every output at once
      push_pulse(1, 2);
      run_frame(4'b0010);
      wait_req(1, 20);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req", o_req, 0);
      chk("arst_busy", o_busy, 0);
      chk("arst_active", o_active_ch, 0);
      chk("arst_cnt", o_frame_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // nothing enabled: done two cycles after start
      push_done(4'b0000, 4'b0000);
      run_frame(4'b0000);
      wait_done(10);
      @(negedge clk);
      chk("f7_cnt", o_frame_cnt, 1);

      repeat (3) @(negedge clk);
      chk("pulse_q_empty", exp_pulse.size(), 0);
      chk("done_q_empty", exp_done.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
